uart_frame_arbiter: RTL and testbench
=====================================

Name: uart_frame_arbiter

Overview:
- Shares one byte-level UART transmitter between NUM_CH requesters.
- Each requester offers a fixed-length payload. The block grants channels round-robin, latches the granted payload and frames it as header, channel id, payload, then XOR checksum.
- It hands bytes to the transmitter one at a time over a start/busy handshake. It sits between the sensor/command producers and the UART TX byte engine.

Parameters:
- NUM_CH, 4, number of requesters (2..8).
- PAYLOAD_BYTES, 12, payload bytes per frame.
- HEADER, 8'hF0, first byte of every frame.
- ACK_TIMEOUT, 16, cycles to wait for byte_busy to rise after byte_start.

Ports:
- clk_50  in  1  system clock, 50 MHz.
- rst  in  1  synchronous reset, active-high.
- req  in  NUM_CH  level request per channel.
- frame_data  in  NUM_CH*PAYLOAD_BYTES*8  payloads; channel i occupies slice [i*PAYLOAD_BYTES*8 +: PAYLOAD_BYTES*8].
- gnt  out  NUM_CH  one-hot, one-cycle pulse when channel's payload is captured.
- busy  out  1  high from grant cycle until frame end.
- done  out  1  one-cycle pulse after last byte completes.
- err  out  1  one-cycle pulse on byte-handshake timeout.
- byte_data  out  8  byte offered to transmitter.
- byte_start  out  1  one-cycle pulse; byte_data valid in same cycle.
- byte_busy  in  1  transmitter busy, high while shifting a byte.

Behaviour:
- Reset and registering:
  - All outputs are registered.
  - rst=1 at any clock edge forces: state IDLE; gnt=0, busy=0, done=0, err=0, byte_data=0, byte_start=0; priority pointer=0; byte index=0; checksum=0.
  - Reset mid-frame aborts silently: no done, no err.
- Frame format:
  - Total length is PAYLOAD_BYTES+3 bytes, sent in this order: HEADER, {id}, payload bytes, checksum.
  - {id} is the channel index zero-extended to 8 bits.
  - Payload is sent most-significant byte of the slice first.
  - Checksum = XOR of the id byte and all payload bytes. HEADER is excluded.
- Arbitration:
  - Round-robin. Pointer p is the highest-priority channel; search order is p, p+1, ... modulo NUM_CH.
  - After granting channel k, p becomes (k+1) mod NUM_CH. This also applies when the frame ends in err.
- Requester handshake:
  - The requester holds req and frame_data stable until it sees gnt.
  - The payload is latched on the grant edge; frame_data changes after that are ignored.
  - A req still high after done competes again. It is not re-granted if another channel is requesting and has priority.
- FSM states:
  - IDLE:
    - If any req is high: pulse gnt[k], set busy=1, latch payload, clear index and checksum, go to SEND.
    - Grant latency: req seen at edge n gives gnt high during cycle n+1.
  - SEND:
    - Wait while byte_busy=1.
    - When byte_busy=0: drive byte_data=byte[index], pulse byte_start, and fold the byte into the checksum if it is the id or a payload byte. Go to WAIT_ACK and clear the timeout counter.
  - WAIT_ACK:
    - byte_busy=1 goes to WAIT_DONE.
    - Otherwise the counter increments. On reaching ACK_TIMEOUT: pulse err, set busy=0, go to IDLE.
  - WAIT_DONE:
    - On byte_busy=0: if index is the last byte, go to FINISH; otherwise increment index and go to SEND.
  - FINISH:
    - Pulse done, set busy=0, go to IDLE. A new grant may occur on the next edge.
- Grant and busy timing:
  - No grant is issued while busy=1.
  - gnt and done are never high in the same cycle.
  - byte_start never pulses on consecutive cycles.
- Boundary cases:
  - All req high: grants in order 0,1,2,3,0,...
  - A single requester holding req high gets back-to-back frames, separated by the one-cycle FINISH and one IDLE cycle.
  - req drops before grant: no grant.

Test Plan:
- req=4'b0001, payload 0x01..0x0C (MS first), model transmitter busy 10 cycles/byte:
  - gnt=4'b0001 one cycle after req.
  - Byte stream F0 00 01 02 03 04 05 06 07 08 09 0A 0B 0C 0C (checksum 0x0C).
  - done pulses once; busy low after.
- req=4'b1111 held, continuous:
  - gnt order 0001, 0010, 0100, 1000, 0001.
  - id bytes 00, 01, 02, 03, 00.
- Transmitter never raises byte_busy:
  - err pulses 16 cycles after first byte_start; busy=0, state IDLE.
  - Next grant follows the pointer rule: ch1 when req=4'b0011.
- byte_busy held high at grant time:
  - No byte_start until byte_busy falls.
  - Then F0 is issued exactly one cycle later.
- rst=1 asserted during payload byte 5:
  - Next cycle all outputs are 0; no done or err.
  - After release with req=4'b0100, the granted channel is 2 (pointer reset to 0, first active).
- Change frame_data of ch0 the cycle after gnt: transmitted bytes still match the value latched at grant.

Source files
------------

// File: rtl/uart_frame_arbiter_if.sv
// Bus bundle between the frame arbiter, its requesters and the UART TX byte engine.
interface uart_frame_arbiter_if #(
  parameter int unsigned NUM_CH        = 4,
  parameter int unsigned PAYLOAD_BYTES = 12
);
  logic [NUM_CH-1:0]                 req;
  logic [NUM_CH*PAYLOAD_BYTES*8-1:0] frame_data;
  logic [NUM_CH-1:0]                 gnt;
  logic                              busy;
  logic                              done;
  logic                              err;
  logic [7:0]                        byte_data;
  logic                              byte_start;
  logic                              byte_busy;

  modport master (
    output req, frame_data, byte_busy,
    input  gnt, busy, done, err, byte_data, byte_start
  );

  modport slave (
    input  req, frame_data, byte_busy,
    output gnt, busy, done, err, byte_data, byte_start
  );
endinterface

// File: rtl/uart_frame_arbiter.sv
// Round-robin arbiter that frames a granted payload (header, id, payload, XOR checksum)
// and feeds it byte by byte to a shared UART transmitter over a start/busy handshake.
module uart_frame_arbiter #(
  parameter int unsigned NUM_CH        = 4,
  parameter int unsigned PAYLOAD_BYTES = 12,
  parameter logic [7:0]  HEADER        = 8'hF0,
  parameter int unsigned ACK_TIMEOUT   = 16
) (
  input logic                 clk_50,
  input logic                 rst,
  uart_frame_arbiter_if.slave bus
);
  localparam int unsigned CH_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int unsigned PL_W     = PAYLOAD_BYTES * 8;
  localparam int unsigned LAST_IDX = PAYLOAD_BYTES + 2;
  localparam int unsigned IDX_W    = $clog2(PAYLOAD_BYTES + 3);
  localparam int unsigned TO_W     = $clog2(ACK_TIMEOUT + 1);

  typedef enum logic [2:0] {IDLE, SEND, WAIT_ACK, WAIT_DONE, FINISH} state_t;

  state_t            state_q, state_d;
  logic [CH_W-1:0]   ptr_q, ptr_d;
  logic [CH_W-1:0]   ch_q, ch_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [TO_W-1:0]   tcnt_q, tcnt_d;
  logic [7:0]        csum_q, csum_d;
  logic [PL_W-1:0]   pl_q, pl_d;
  logic [NUM_CH-1:0] gnt_q, gnt_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic              start_q, start_d;
  logic [7:0]        bdata_q, bdata_d;

  logic              found;
  logic [CH_W-1:0]   win;
  logic [CH_W:0]     cand_sum;
  logic [CH_W-1:0]   cand;
  logic [PL_W-1:0]   win_payload;
  logic [7:0]        tx_byte;

  // Search starts at the pointer and wraps modulo NUM_CH; first requester wins.
  always_comb begin
    found    = 1'b0;
    win      = '0;
    cand_sum = '0;
    cand     = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      cand_sum = {1'b0, ptr_q} + (CH_W+1)'(i);
      if (cand_sum >= (CH_W+1)'(NUM_CH)) cand_sum = cand_sum - (CH_W+1)'(NUM_CH);
      cand = cand_sum[CH_W-1:0];
      if (!found && bus.req[cand]) begin
        found = 1'b1;
        win   = cand;
      end
    end
  end

  always_comb begin
    win_payload = '0;
    for (int unsigned c = 0; c < NUM_CH; c++) begin
      if (win == CH_W'(c)) win_payload = bus.frame_data[c*PL_W +: PL_W];
    end
  end

  // Payload is shifted left after each payload byte, so the MS byte is always on top.
  always_comb begin
    if (idx_q == '0)                     tx_byte = HEADER;
    else if (idx_q == IDX_W'(1))         tx_byte = 8'(ch_q);
    else if (idx_q == IDX_W'(LAST_IDX))  tx_byte = csum_q;
    else                                 tx_byte = pl_q[PL_W-1 -: 8];
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    ch_d    = ch_q;
    idx_d   = idx_q;
    tcnt_d  = tcnt_q;
    csum_d  = csum_q;
    pl_d    = pl_q;
    gnt_d   = '0;
    busy_d  = busy_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    start_d = 1'b0;
    bdata_d = bdata_q;
    unique case (state_q)
      IDLE: begin
        if (found) begin
          gnt_d   = NUM_CH'(1) << win;
          busy_d  = 1'b1;
          ch_d    = win;
          pl_d    = win_payload;
          idx_d   = '0;
          csum_d  = '0;
          ptr_d   = (win == CH_W'(NUM_CH - 1)) ? '0 : win + 1'b1;
          state_d = SEND;
        end
      end
      SEND: begin
        if (!bus.byte_busy) begin
          bdata_d = tx_byte;
          start_d = 1'b1;
          tcnt_d  = '0;
          state_d = WAIT_ACK;
          if (idx_q != '0 && idx_q != IDX_W'(LAST_IDX)) csum_d = csum_q ^ tx_byte;
          if (idx_q > IDX_W'(1) && idx_q != IDX_W'(LAST_IDX)) pl_d = pl_q << 8;
        end
      end
      WAIT_ACK: begin
        if (bus.byte_busy) begin
          state_d = WAIT_DONE;
        end else begin
          tcnt_d = tcnt_q + 1'b1;
          if (tcnt_d == TO_W'(ACK_TIMEOUT)) begin
            err_d   = 1'b1;
            busy_d  = 1'b0;
            state_d = IDLE;
          end
        end
      end
      WAIT_DONE: begin
        if (!bus.byte_busy) begin
          if (idx_q == IDX_W'(LAST_IDX)) begin
            state_d = FINISH;
          end else begin
            idx_d   = idx_q + 1'b1;
            state_d = SEND;
          end
        end
      end
      FINISH: begin
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_50) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      ch_q    <= '0;
      idx_q   <= '0;
      tcnt_q  <= '0;
      csum_q  <= '0;
      pl_q    <= '0;
      gnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      start_q <= 1'b0;
      bdata_q <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      ch_q    <= ch_d;
      idx_q   <= idx_d;
      tcnt_q  <= tcnt_d;
      csum_q  <= csum_d;
      pl_q    <= pl_d;
      gnt_q   <= gnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
      start_q <= start_d;
      bdata_q <= bdata_d;
    end
  end

  assign bus.gnt        = gnt_q;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.err        = err_q;
  assign bus.byte_start = start_q;
  assign bus.byte_data  = bdata_q;
endmodule

// File: tb/tb_uart_frame_arbiter.sv
// Directed bench for uart_frame_arbiter: table of single-frame vectors plus
// hand-written sequences for round-robin, timeout, busy-at-grant and mid-frame reset.
module tb_uart_frame_arbiter;
  localparam int unsigned NCH    = 4;
  localparam int unsigned PB     = 12;
  localparam int unsigned PLW    = PB * 8;
  localparam int unsigned TX_CYC = 10;
  localparam logic [7:0]  HDR    = 8'hF0;

  logic clk_50 = 1'b0;
  logic rst    = 1'b1;
  always #10 clk_50 = ~clk_50;

  uart_frame_arbiter_if #(.NUM_CH(NCH), .PAYLOAD_BYTES(PB)) bus ();

  uart_frame_arbiter #(
    .NUM_CH(NCH), .PAYLOAD_BYTES(PB), .HEADER(HDR), .ACK_TIMEOUT(16)
  ) dut (
    .clk_50(clk_50),
    .rst(rst),
    .bus(bus)
  );

  int tests  = 0;
  int failed = 0;

  // Transmitter model and monitor state
  logic       force_busy = 1'b0;
  logic       tx_dead    = 1'b0;
  int         tx_cnt     = 0;
  logic [7:0] byte_q[$];
  logic [7:0] id_q[$];
  logic [NCH-1:0] gnt_q[$];
  int         frame_pos  = 99;
  int         n_start    = 0;
  int         n_done     = 0;
  int         n_err      = 0;
  int         viol       = 0;
  logic       prev_start = 1'b0;

  assign bus.byte_busy = force_busy | (tx_cnt != 0);

  always @(negedge clk_50) begin
    if (bus.byte_start) begin
      byte_q.push_back(bus.byte_data);
      if (frame_pos == 1) id_q.push_back(bus.byte_data);
      frame_pos++;
      n_start++;
      if (prev_start) viol++;
    end
    if (bus.gnt != '0) begin
      gnt_q.push_back(bus.gnt);
      frame_pos = 0;
      if ($countones(bus.gnt) != 1) viol++;
      if (bus.done) viol++;
    end
    if (bus.done) n_done++;
    if (bus.err) n_err++;
    prev_start = bus.byte_start;
    if (bus.byte_start && !tx_dead) tx_cnt = TX_CYC;
    else if (tx_cnt != 0) tx_cnt--;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk_50);
    rst = 1'b1;
    bus.req = '0;
    repeat (2) @(negedge clk_50);
    rst = 1'b0;
    @(negedge clk_50);
  endtask

  task automatic wait_gnt(output int lat);
    lat = 0;
    while (lat < 50) begin
      @(negedge clk_50);
      lat++;
      if (bus.gnt != '0) return;
    end
    lat = -1;
  endtask

  task automatic wait_end(output logic ok);
    ok = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk_50);
      if (bus.done || bus.err) begin
        ok = 1'b1;
        return;
      end
    end
  endtask

  typedef struct {
    logic [NCH-1:0] req;
    logic [PLW-1:0] payload;
    logic [NCH-1:0] exp_gnt;
    logic [7:0]     exp_id;
    logic [7:0]     exp_csum;
  } vec_t;

  vec_t vec[6];

  initial begin
    int          lat;
    int          cnt;
    int          d0;
    int          e0;
    int          s0;
    logic        ok;
    logic [PLW-1:0] sh;
    logic [7:0]  eb;

    vec[0] = '{4'b0001, 96'h0102030405060708090A0B0C, 4'b0001, 8'h00, 8'h0C};
    vec[1] = '{4'b0001, {12{8'hFF}},                   4'b0001, 8'h00, 8'h00};
    vec[2] = '{4'b1010, {12{8'hA5}},                   4'b0010, 8'h01, 8'h01};
    vec[3] = '{4'b1010, 96'h5A,                        4'b1000, 8'h03, 8'h59};
    vec[4] = '{4'b0110, 96'h123456789ABCDEF011223344, 4'b0010, 8'h01, 8'h45};
    vec[5] = '{4'b0100, {8'h80, 88'h0},                4'b0100, 8'h02, 8'h82};

    bus.req        = '0;
    bus.frame_data = '0;
    do_reset();
    check("reset_outputs",
          {bus.gnt, bus.busy, bus.done, bus.err, bus.byte_data, bus.byte_start},
          '0);

    // Table-driven single frames; frame_data is scrambled right after each grant.
    for (int v = 0; v < 6; v++) begin
      @(negedge clk_50);
      byte_q.delete();
      d0 = n_done;
      e0 = n_err;
      bus.frame_data = {NCH{vec[v].payload}};
      bus.req = vec[v].req;
      wait_gnt(lat);
      check("gnt_latency", lat, 1);
      check("gnt_value", bus.gnt, vec[v].exp_gnt);
      bus.req = '0;
      bus.frame_data = ~bus.frame_data;
      wait_end(ok);
      check("frame_end_seen", ok, 1);
      @(negedge clk_50);
      check("busy_after_done", bus.busy, 0);
      check("done_count", n_done - d0, 1);
      check("no_err", n_err - e0, 0);
      check("frame_len", byte_q.size(), PB + 3);
      if (byte_q.size() == PB + 3) begin
        check("hdr_byte", byte_q[0], HDR);
        check("id_byte", byte_q[1], vec[v].exp_id);
        sh = vec[v].payload;
        for (int b = 0; b < PB; b++) begin
          eb = sh[PLW-1 -: 8];
          sh = sh << 8;
          check("payload_byte", byte_q[b+2], eb);
        end
        check("csum_byte", byte_q[PB+2], vec[v].exp_csum);
      end
    end

    // All requesters held high: strict rotation 0,1,2,3,0.
    do_reset();
    gnt_q.delete();
    id_q.delete();
    bus.frame_data = {NCH{vec[4].payload}};
    bus.req = 4'b1111;
    cnt = 0;
    while (gnt_q.size() < 5 && cnt < 5000) begin
      @(negedge clk_50);
      cnt++;
    end
    bus.req = '0;
    check("rr_gnt_timeout", cnt < 5000, 1);
    wait_end(ok);
    check("rr_last_frame_end", ok, 1);
    check("rr_gnt_count", gnt_q.size(), 5);
    check("rr_id_count", id_q.size(), 5);
    if (gnt_q.size() == 5 && id_q.size() == 5) begin
      for (int i = 0; i < 5; i++) begin
        check("rr_gnt_order", gnt_q[i], 32'(1) << (i % 4));
        check("rr_id_order", id_q[i], i % 4);
      end
    end

    // Transmitter never acknowledges: err 16 cycles after byte_start, then pointer moves on.
    do_reset();
    tx_dead = 1'b1;
    s0 = n_start;
    bus.req = 4'b0001;
    wait_gnt(lat);
    check("to_gnt", bus.gnt, 4'b0001);
    bus.req = '0;
    cnt = 0;
    while (!bus.byte_start && cnt < 50) begin
      @(negedge clk_50);
      cnt++;
    end
    check("to_first_start", bus.byte_start, 1);
    check("to_first_byte", bus.byte_data, HDR);
    cnt = 0;
    while (cnt < 40) begin
      @(negedge clk_50);
      cnt++;
      if (bus.err) break;
    end
    check("to_err_delay", cnt, 16);
    check("to_busy_low", bus.busy, 0);
    @(negedge clk_50);
    check("to_err_pulse", bus.err, 0);
    check("to_single_start", n_start - s0, 1);
    tx_dead = 1'b0;
    bus.req = 4'b0011;
    wait_gnt(lat);
    check("to_next_gnt", bus.gnt, 4'b0010);
    bus.req = '0;
    wait_end(ok);
    check("to_recover_done", bus.done, 1);

    // Transmitter busy at grant: no byte until it frees up, then header one cycle later.
    @(negedge clk_50);
    force_busy = 1'b1;
    bus.req = 4'b0001;
    wait_gnt(lat);
    check("hold_gnt", bus.gnt, 4'b0001);
    bus.req = '0;
    s0 = n_start;
    repeat (6) @(negedge clk_50);
    check("hold_no_start", n_start - s0, 0);
    force_busy = 1'b0;
    cnt = 0;
    while (cnt < 20) begin
      @(negedge clk_50);
      cnt++;
      if (bus.byte_start) break;
    end
    check("hold_start_delay", cnt, 1);
    check("hold_hdr", bus.byte_data, HDR);
    wait_end(ok);
    check("hold_done", bus.done, 1);

    // Reset during payload byte 5 aborts silently and clears the pointer.
    @(negedge clk_50);
    bus.frame_data = {NCH{vec[0].payload}};
    bus.req = 4'b0001;
    wait_gnt(lat);
    bus.req = '0;
    cnt = 0;
    lat = 0;
    while (cnt < 7 && lat < 500) begin
      @(negedge clk_50);
      lat++;
      if (bus.byte_start) cnt++;
    end
    check("rst_reach_byte5", cnt, 7);
    d0 = n_done;
    e0 = n_err;
    rst = 1'b1;
    @(negedge clk_50);
    check("rst_mid_outputs",
          {bus.gnt, bus.busy, bus.done, bus.err, bus.byte_data, bus.byte_start},
          '0);
    rst = 1'b0;
    repeat (3) @(negedge clk_50);
    check("rst_no_done", n_done - d0, 0);
    check("rst_no_err", n_err - e0, 0);
    bus.req = 4'b0100;
    wait_gnt(lat);
    check("rst_next_gnt", bus.gnt, 4'b0100);
    bus.req = '0;
    wait_end(ok);
    check("rst_next_done", bus.done, 1);

    repeat (3) @(negedge clk_50);
    check("protocol_violations", viol, 0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule
